// File: rtl/noc_input_buffer.sv
// noc_input_buffer: per-port show-ahead flit FIFO with credit return and sticky overflow flag
module noc_input_buffer #(
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    data_i,
    input  logic          valid_i,
    input  logic          remove_i,
    output logic [7:0]    data_o,
    output logic          valid_o,
    output logic          credit_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          overflow_o
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [CW-1:0] cnt;
    logic          push_ok, pop_ok;

    assign valid_o = cnt != '0;
    assign full_o  = cnt == CW'(DEPTH);
    assign count_o = cnt;
    assign data_o  = mem[rp];
    assign pop_ok  = remove_i && valid_o;
    assign push_ok = valid_i && (!full_o || pop_ok);

    // flit storage; contents survive reset, pushes are ignored during it
    always_ff @(posedge clk)
        if (!rst && push_ok) mem[wp] <= data_i;

    // pointers, occupancy, credit pulse and sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            wp         <= '0;
            rp         <= '0;
            cnt        <= '0;
            credit_o   <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            if (push_ok) wp <= wp + 1'b1;
            if (pop_ok) rp <= rp + 1'b1;
            cnt      <= cnt + CW'(push_ok) - CW'(pop_ok);
            credit_o <= pop_ok;
            if (valid_i && !push_ok) overflow_o <= 1'b1;
        end
    end

    a_cnt_max:  assert property (@(posedge clk) disable iff (rst) cnt <= CW'(DEPTH));
    a_ptr_diff: assert property (@(posedge clk) disable iff (rst) AW'(wp - rp) == cnt[AW-1:0]);
    a_valid:    assert property (@(posedge clk) disable iff (rst) valid_o == (cnt != '0));
endmodule

// File: tb/tb_noc_input_buffer.sv
// tb_noc_input_buffer: directed vector table plus randomized queue-model check of noc_input_buffer
module tb_noc_input_buffer;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_i = '0;
    logic       valid_i = 1'b0;
    logic       remove_i = 1'b0;
    logic [7:0] data_o;
    logic       valid_o, credit_o, full_o, overflow_o;
    logic [2:0] count_o;

    int checks = 0;
    int fails = 0;

    noc_input_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .remove_i(remove_i),
        .data_o(data_o), .valid_o(valid_o), .credit_o(credit_o), .count_o(count_o),
        .full_o(full_o), .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r, v;
        logic [7:0] d;
        logic       rm, ev;
        logic [7:0] ed;
        int         ec;
        logic       ef, eo, ecr;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [7:0] d, input logic rm);
        @(negedge clk);
        rst = r;
        valid_i = v;
        data_i = d;
        remove_i = rm;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic ev, input logic [7:0] ed, input int ec,
                           input logic ef, input logic eo, input logic ecr);
        chk({tag, " valid"}, int'(valid_o), int'(ev));
        if (ev) chk({tag, " data"}, int'(data_o), int'(ed));
        chk({tag, " count"}, int'(count_o), ec);
        chk({tag, " full"}, int'(full_o), int'(ef));
        chk({tag, " overflow"}, int'(overflow_o), int'(eo));
        chk({tag, " credit"}, int'(credit_o), int'(ecr));
    endtask

    initial begin
        logic [7:0] q[$];
        logic       m_ovf, m_cr, pop, push, r, v, rm;
        logic [7:0] d;
        int         credits;

        //          r  v  d      rm ev ed     ec ef eo cr
        tbl.push_back('{1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 8'h23, 0, 1, 8'h23, 1, 0, 0, 0});
        tbl.push_back('{0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 1});
        tbl.push_back('{0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 8'h11, 0, 1, 8'h11, 1, 0, 0, 0});
        tbl.push_back('{0, 1, 8'h12, 0, 1, 8'h11, 2, 0, 0, 0});
        tbl.push_back('{0, 1, 8'h13, 0, 1, 8'h11, 3, 0, 0, 0});
        tbl.push_back('{0, 1, 8'h14, 0, 1, 8'h11, 4, 1, 0, 0});
        tbl.push_back('{0, 1, 8'h15, 0, 1, 8'h11, 4, 1, 1, 0});
        tbl.push_back('{0, 0, 8'h00, 1, 1, 8'h12, 3, 0, 1, 1});
        tbl.push_back('{0, 0, 8'h00, 1, 1, 8'h13, 2, 0, 1, 1});
        tbl.push_back('{0, 0, 8'h00, 1, 1, 8'h14, 1, 0, 1, 1});
        tbl.push_back('{0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 1, 1});
        tbl.push_back('{1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 8'h21, 0, 1, 8'h21, 1, 0, 0, 0});
        tbl.push_back('{0, 1, 8'h22, 0, 1, 8'h21, 2, 0, 0, 0});
        tbl.push_back('{0, 1, 8'h23, 0, 1, 8'h21, 3, 0, 0, 0});
        tbl.push_back('{0, 1, 8'h24, 0, 1, 8'h21, 4, 1, 0, 0});
        tbl.push_back('{0, 1, 8'h55, 1, 1, 8'h22, 4, 1, 0, 1});
        tbl.push_back('{0, 0, 8'h00, 1, 1, 8'h23, 3, 0, 0, 1});
        tbl.push_back('{0, 0, 8'h00, 1, 1, 8'h24, 2, 0, 0, 1});
        tbl.push_back('{0, 0, 8'h00, 1, 1, 8'h55, 1, 0, 0, 1});
        tbl.push_back('{0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 1});
        tbl.push_back('{0, 1, 8'h31, 1, 1, 8'h31, 1, 0, 0, 0});
        tbl.push_back('{0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 1});
        tbl.push_back('{0, 1, 8'h61, 0, 1, 8'h61, 1, 0, 0, 0});
        tbl.push_back('{0, 1, 8'h62, 0, 1, 8'h61, 2, 0, 0, 0});
        tbl.push_back('{0, 1, 8'h63, 0, 1, 8'h61, 3, 0, 0, 0});
        tbl.push_back('{1, 1, 8'h77, 0, 0, 8'h00, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 8'h44, 0, 1, 8'h44, 1, 0, 0, 0});
        tbl.push_back('{0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 1});

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].rm);
            chk_all($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].ec, tbl[i].ef, tbl[i].eo, tbl[i].ecr);
        end

        // streaming: push and pop every cycle, occupancy pinned at 1
        credits = 0;
        step(0, 1, 8'h00, 0);
        chk_all("stream fill", 1, 8'h00, 1, 0, 0, 0);
        for (int i = 1; i < 20; i++) begin
            step(0, 1, 8'(i), 1);
            credits += int'(credit_o);
            chk_all($sformatf("stream%0d", i), 1, 8'(i), 1, 0, 0, 1);
        end
        step(0, 0, 8'h00, 1);
        credits += int'(credit_o);
        chk_all("stream drain", 0, 8'h00, 0, 0, 0, 1);
        step(0, 0, 8'h00, 0);
        credits += int'(credit_o);
        chk("stream credit total", credits, 20);

        // randomized traffic against a queue model
        step(1, 0, 8'h00, 0);
        q.delete();
        m_ovf = 0;
        m_cr = 0;
        for (int c = 0; c < 3000; c++) begin
            r = $urandom_range(0, 199) == 0;
            v = $urandom_range(0, 99) < ((c / 300) % 2 == 0 ? 75 : 35);
            rm = $urandom_range(0, 99) < ((c / 300) % 2 == 0 ? 35 : 75);
            d = 8'($urandom);
            if (r) begin
                q.delete();
                m_ovf = 0;
                m_cr = 0;
            end else begin
                pop = rm && q.size() != 0;
                push = v && (q.size() < DEPTH || pop);
                if (v && !push) m_ovf = 1;
                if (pop) void'(q.pop_front());
                if (push) q.push_back(d);
                m_cr = pop;
            end
            step(r, v, d, rm);
            chk_all($sformatf("rand%0d", c), q.size() != 0, q.size() != 0 ? q[0] : 8'h00,
                    q.size(), q.size() == DEPTH, m_ovf, m_cr);
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule

// File: doc/noc_input_buffer.md
Name: noc_input_buffer

Overview:
- Per-port input FIFO for the 5-port mesh router. One instance per N/S/E/W/L port.
- Captures single-byte flits arriving from the link or local node. Flit format: [7:4] = destination X, [3:0] = destination Y.
- Presents the head flit to the route logic as <port>_data_i / <port>_valid_i.
- Pops on the route logic's <port>_remove and returns one credit upstream per popped flit.

Parameters:
- DEPTH, 4, number of flit entries; power of two, at least 2.
- CW, $clog2(DEPTH)+1, width of count_o (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- data_i  in  8  incoming flit.
- valid_i  in  1  push request; data_i is qualified by valid_i.
- remove_i  in  1  pop request from the route logic (<port>_remove).
- data_o  out  8  head flit; drives the route logic's <port>_data_i.
- valid_o  out  1  FIFO non-empty; drives the route logic's <port>_valid_i.
- credit_o  out  1  one-cycle pulse per accepted pop; returned to the upstream sender.
- count_o  out  CW  current occupancy, 0..DEPTH.
- full_o  out  1  count_o == DEPTH.
- overflow_o  out  1  sticky flag: a push was dropped while full.

Behaviour:
- Storage: DEPTH x 8 register array, write pointer wp and read pointer rp (each log2(DEPTH) bits, wrap modulo DEPTH), occupancy counter cnt (CW bits).
- Reset (rst=1 at an edge):
  - wp, rp, cnt, credit_o and overflow_o are cleared to 0. valid_o=0, full_o=0, count_o=0 from the next cycle.
  - Array contents are not cleared; data_o is don't-care while valid_o=0.
  - valid_i and remove_i are ignored in a reset cycle. Reset mid-stream discards all queued flits and issues no credits for them.
- Show-ahead read:
  - data_o = mem[rp] combinationally from registered state.
  - valid_o = (cnt != 0), full_o = (cnt == DEPTH), count_o = cnt.
- Push accepted: push_ok = valid_i && (!full_o || pop_ok). On acceptance, mem[wp] <= data_i and wp <= wp+1.
- Pop accepted: pop_ok = remove_i && valid_o. On acceptance, rp <= rp+1.
- remove_i while empty is ignored: no pointer change, no credit.
- Latency: a flit pushed at edge t appears on data_o/valid_o after edge t (zero bubble). Minimum push-to-pop is 1 cycle.
- Occupancy update:
  - cnt <= cnt + push_ok - pop_ok.
  - Simultaneous push+pop when non-empty leaves cnt unchanged.
  - Simultaneous push+pop when full: pop frees the slot, push is accepted, cnt stays DEPTH, overflow_o is not set.
  - Simultaneous push+pop when empty: pop ignored, push accepted, cnt becomes 1.
- Overflow: valid_i && full_o && !pop_ok drops the flit and sets overflow_o <= 1. overflow_o holds until rst; wp and cnt are unchanged.
- Credit: credit_o <= pop_ok (registered, one pulse per accepted pop, one cycle after the pop edge).
  - Back-to-back pops produce back-to-back credit pulses.
  - Total credit pulses always equal total accepted pops since reset.
- Upstream contract: the sender starts with DEPTH credits and never pushes without a credit. Overflow therefore only indicates a protocol violation, and the block must remain functional after one.
- Invariants (checked by assertions): cnt <= DEPTH; (wp - rp) mod DEPTH == cnt mod DEPTH; valid_o == (cnt != 0).

Test Plan:
- Reset then push 0x23 (valid_i=1 for 1 cycle) -> next cycle valid_o=1, data_o=0x23, count_o=1. Pulse remove_i -> credit_o=1 one cycle later, valid_o=0, count_o=0.
- DEPTH=4: push 0x11, 0x12, 0x13, 0x14 back to back -> full_o=1, count_o=4. Push 0x15 with no pop -> dropped, overflow_o=1 sticky. Pop four times -> data_o sequence 0x11..0x14, four credit_o pulses, no 0x15 seen.
- Full FIFO with valid_i=1 data 0x55 and remove_i=1 in the same cycle -> count_o stays 4, overflow_o stays 0. After draining, 0x55 emerges last.
- Empty FIFO with remove_i=1 and valid_i=1 (0x31) in the same cycle -> no credit_o, count_o=1, data_o=0x31.
- Continuous push and pop every cycle for 20 flits (0x00..0x13) -> count_o stays at 1 after fill, pointers wrap 5 times, output order preserved, 20 credits total.
- Fill 3 flits, assert rst for 1 cycle while valid_i=1 -> count_o=0, valid_o=0, overflow_o=0, no credit_o. Next push of 0x44 appears as head.
